// File: rtl/alsu_pkg.sv
// Shared opcode encodings and LED patterns for the ALSU.
package alsu_pkg;

  localparam logic [2:0] OP_AND    = 3'b000;
  localparam logic [2:0] OP_XOR    = 3'b001;
  localparam logic [2:0] OP_ADD    = 3'b010;
  localparam logic [2:0] OP_MULT   = 3'b011;
  localparam logic [2:0] OP_SHIFT  = 3'b100;
  localparam logic [2:0] OP_ROTATE = 3'b101;
  localparam logic [2:0] OP_INV6   = 3'b110;
  localparam logic [2:0] OP_INV7   = 3'b111;

  localparam logic [15:0] LED_ON  = 16'hFFFF;
  localparam logic [15:0] LED_OFF = 16'h0000;

endpackage

// File: rtl/alsu_blinker.sv
// Warning-LED blinker: toggles all LEDs every BLINK_DIV cycles while enabled,
// and clears both LEDs and counter on the first disabled edge.
module alsu_blinker
  import alsu_pkg::*;
#(
  parameter int unsigned BLINK_DIV = 25_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] leds
);

  localparam int unsigned CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic [15:0]   r_leds;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_leds <= LED_OFF;
    end else if (!en) begin
      r_cnt  <= '0;
      r_leds <= LED_OFF;
    end else if (r_cnt == CNT_MAX) begin
      r_cnt  <= '0;
      r_leds <= ~r_leds;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign leds = r_leds;

endmodule

// File: rtl/alsu_core.sv
// Two-stage registered arithmetic-logic-shift unit: inputs registered, then
// result/invalid computed from those registers; drives the warning blinker.
module alsu_core
  import alsu_pkg::*;
#(
  parameter string       INPUT_PRIORITY = "A",
  parameter string       FULL_ADDER     = "ON",
  parameter int unsigned BLINK_DIV      = 25_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  A,
  input  logic [2:0]  B,
  input  logic [2:0]  opcode,
  input  logic        cin,
  input  logic        serial_in,
  input  logic        direction,
  input  logic        red_op_A,
  input  logic        red_op_B,
  input  logic        bypass_A,
  input  logic        bypass_B,
  output logic [5:0]  result,
  output logic        invalid,
  output logic [15:0] leds
);

  localparam bit PRIO_A  = (INPUT_PRIORITY == "A");
  localparam bit USE_CIN = (FULL_ADDER == "ON");

  logic [2:0] r_a, r_b, r_opcode;
  logic       r_cin, r_sin, r_dir, r_red_a, r_red_b, r_byp_a, r_byp_b;
  logic [5:0] r_result;
  logic       r_invalid;

  logic [5:0] w_result_d;
  logic       w_invalid_d;
  logic       w_red_pick_a, w_byp_pick_a, w_blink_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_opcode  <= '0;
      r_cin     <= 1'b0;
      r_sin     <= 1'b0;
      r_dir     <= 1'b0;
      r_red_a   <= 1'b0;
      r_red_b   <= 1'b0;
      r_byp_a   <= 1'b0;
      r_byp_b   <= 1'b0;
      r_result  <= '0;
      r_invalid <= 1'b0;
    end else begin
      r_a       <= A;
      r_b       <= B;
      r_opcode  <= opcode;
      r_cin     <= cin;
      r_sin     <= serial_in;
      r_dir     <= direction;
      r_red_a   <= red_op_A;
      r_red_b   <= red_op_B;
      r_byp_a   <= bypass_A;
      r_byp_b   <= bypass_B;
      r_result  <= w_result_d;
      r_invalid <= w_invalid_d;
    end
  end

  // When both flags of a pair are set, INPUT_PRIORITY decides the operand.
  assign w_red_pick_a = r_red_a && (!r_red_b || PRIO_A);
  assign w_byp_pick_a = r_byp_a && (!r_byp_b || PRIO_A);

  always_comb begin
    w_result_d  = r_result;
    w_invalid_d = 1'b0;
    if (r_opcode == OP_INV6 || r_opcode == OP_INV7 ||
        ((r_red_a || r_red_b) && r_opcode != OP_AND && r_opcode != OP_XOR)) begin
      w_invalid_d = 1'b1;
      w_result_d  = '0;
    end else if (r_byp_a || r_byp_b) begin
      w_result_d = {3'b000, w_byp_pick_a ? r_a : r_b};
    end else begin
      case (r_opcode)
        OP_AND: begin
          if (r_red_a || r_red_b) w_result_d = {5'b0, w_red_pick_a ? &r_a : &r_b};
          else                    w_result_d = {3'b000, r_a & r_b};
        end
        OP_XOR: begin
          if (r_red_a || r_red_b) w_result_d = {5'b0, w_red_pick_a ? ^r_a : ^r_b};
          else                    w_result_d = {3'b000, r_a ^ r_b};
        end
        OP_ADD:    w_result_d = {3'b000, r_a} + {3'b000, r_b} + {5'b0, r_cin & USE_CIN};
        OP_MULT:   w_result_d = {3'b000, r_a} * {3'b000, r_b};
        OP_SHIFT:  w_result_d = r_dir ? {r_result[4:0], r_sin} : {r_sin, r_result[5:1]};
        OP_ROTATE: w_result_d = r_dir ? {r_result[4:0], r_result[5]}
                                      : {r_result[0], r_result[5:1]};
        default:   w_result_d = '0;
      endcase
    end
  end

  // Count only once invalid is already showing; clear on the edge it falls.
  assign w_blink_en = w_invalid_d & r_invalid;

  alsu_blinker #(
    .BLINK_DIV (BLINK_DIV)
  ) u_blinker (
    .clk  (clk),
    .rst  (rst),
    .en   (w_blink_en),
    .leds (leds)
  );

  assign result  = r_result;
  assign invalid = r_invalid;

endmodule

// File: tb/tb_alsu_core.sv
// Directed bench: two ALSU configurations share stimulus; a scoreboard queue
// holds expected outputs keyed by the cycle at which they must appear.
module tb_alsu_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  A, B, opcode;
  logic        cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B;
  logic [5:0]  result_a, result_b;
  logic        invalid_a, invalid_b;
  logic [15:0] leds_a, leds_b;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    int          due;
    string       tag;
    logic [5:0]  r1;
    logic        i1;
    logic [5:0]  r2;
    logic        i2;
    bit          cl;
    logic [15:0] l;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alsu_core #(
    .INPUT_PRIORITY ("A"),
    .FULL_ADDER     ("ON"),
    .BLINK_DIV      (4)
  ) u_dut_a (
    .clk (clk), .rst (rst), .A (A), .B (B), .opcode (opcode), .cin (cin),
    .serial_in (serial_in), .direction (direction), .red_op_A (red_op_A),
    .red_op_B (red_op_B), .bypass_A (bypass_A), .bypass_B (bypass_B),
    .result (result_a), .invalid (invalid_a), .leds (leds_a)
  );

  alsu_core #(
    .INPUT_PRIORITY ("B"),
    .FULL_ADDER     ("OFF"),
    .BLINK_DIV      (4)
  ) u_dut_b (
    .clk (clk), .rst (rst), .A (A), .B (B), .opcode (opcode), .cin (cin),
    .serial_in (serial_in), .direction (direction), .red_op_A (red_op_A),
    .red_op_B (red_op_B), .bypass_A (bypass_A), .bypass_B (bypass_B),
    .result (result_b), .invalid (invalid_b), .leds (leds_b)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic reset_check(input string tag);
    check({tag, "/resA"}, {10'b0, result_a}, 16'h0);
    check({tag, "/invA"}, {15'b0, invalid_a}, 16'h0);
    check({tag, "/ledsA"}, leds_a, 16'h0);
    check({tag, "/resB"}, {10'b0, result_b}, 16'h0);
    check({tag, "/ledsB"}, leds_b, 16'h0);
  endtask

  task automatic push(input int lat, input string tag, input logic [5:0] r1, input logic i1,
                      input logic [5:0] r2, input logic i2, input bit cl, input logic [15:0] l);
    exp_t e;
    e.due = cyc + lat;
    e.tag = tag;
    e.r1  = r1;
    e.i1  = i1;
    e.r2  = r2;
    e.i2  = i2;
    e.cl  = cl;
    e.l   = l;
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic [2:0] a, input logic [2:0] b, input logic [2:0] op,
                       input logic c, input logic sin, input logic dir, input logic ra,
                       input logic rb, input logic ba, input logic bb);
    A = a; B = b; opcode = op; cin = c; serial_in = sin; direction = dir;
    red_op_A = ra; red_op_B = rb; bypass_A = ba; bypass_B = bb;
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      e = sb_q.pop_front();
      check({e.tag, "/resA"}, {10'b0, result_a}, {10'b0, e.r1});
      check({e.tag, "/invA"}, {15'b0, invalid_a}, {15'b0, e.i1});
      check({e.tag, "/resB"}, {10'b0, result_b}, {10'b0, e.r2});
      check({e.tag, "/invB"}, {15'b0, invalid_b}, {15'b0, e.i2});
      if (e.cl) begin
        check({e.tag, "/ledsA"}, leds_a, e.l);
        check({e.tag, "/ledsB"}, leds_b, e.l);
      end
    end
  end

  initial begin
    int guard;
    logic [15:0] exp_leds;
    rst = 1'b0;
    drive(3'd3, 3'd5, 3'b011, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    reset_check("rst_hold");

    // Release reset: one edge captures inputs, the second shows the product.
    rst = 1'b1;
    push(1, "rst_lat1", 6'd0, 0, 6'd0, 0, 1, 16'h0);
    push(2, "rst_mult", 6'd15, 0, 6'd15, 0, 0, 16'h0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1 reset_check("rst_mid");
    @(negedge clk);
    rst = 1'b1;
    push(1, "rst2_lat1", 6'd0, 0, 6'd0, 0, 0, 16'h0);
    push(2, "rst2_mult", 6'd15, 0, 6'd15, 0, 0, 16'h0);
    repeat (2) @(negedge clk);

    // Arithmetic and logic; dut B ignores cin.
    @(negedge clk); drive(3'd7, 3'd7, 3'b010, 1, 0, 0, 0, 0, 0, 0);
    push(2, "add_cin", 6'd15, 0, 6'd14, 0, 0, 16'h0);
    @(negedge clk); opcode = 3'b011;
    push(2, "mult_max", 6'd49, 0, 6'd49, 0, 0, 16'h0);
    @(negedge clk); opcode = 3'b000;
    push(2, "and", 6'd7, 0, 6'd7, 0, 0, 16'h0);
    @(negedge clk); opcode = 3'b001;
    push(2, "xor", 6'd0, 0, 6'd0, 0, 0, 16'h0);

    // Reductions with both flags set; priority differs between the DUTs.
    @(negedge clk); drive(3'b111, 3'b101, 3'b000, 0, 0, 0, 1, 1, 0, 0);
    push(2, "red_and", 6'd1, 0, 6'd0, 0, 0, 16'h0);
    @(negedge clk); opcode = 3'b001;
    push(2, "red_xor", 6'd1, 0, 6'd0, 0, 0, 16'h0);
    @(negedge clk); opcode = 3'b010;
    push(2, "red_add_inv", 6'd0, 1, 6'd0, 1, 0, 16'h0);
    @(negedge clk); drive(3'b111, 3'b100, 3'b001, 0, 0, 0, 0, 1, 0, 0);
    push(2, "red_xor_b", 6'd1, 0, 6'd1, 0, 0, 16'h0);

    // Bypass vs invalid.
    @(negedge clk); drive(3'd5, 3'd2, 3'b110, 0, 0, 0, 0, 0, 1, 0);
    push(2, "byp_inv", 6'd0, 1, 6'd0, 1, 0, 16'h0);
    @(negedge clk); opcode = 3'b010;
    push(2, "byp_a", 6'd5, 0, 6'd5, 0, 0, 16'h0);
    @(negedge clk); drive(3'd5, 3'd2, 3'b000, 0, 0, 0, 0, 0, 1, 1);
    push(2, "byp_both", 6'd5, 0, 6'd2, 0, 0, 16'h0);

    // Rotate left six times from 000001 and wrap back.
    @(negedge clk); drive(3'd1, 3'd1, 3'b000, 0, 0, 0, 0, 0, 0, 0);
    push(2, "preload", 6'd1, 0, 6'd1, 0, 0, 16'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); drive(3'd0, 3'd0, 3'b101, 0, 0, 1, 0, 0, 0, 0);
      push(2, $sformatf("rotl%0d", i), 6'd1 << ((i + 1) % 6), 0, 6'd1 << ((i + 1) % 6), 0,
           0, 16'h0);
    end
    @(negedge clk); drive(3'd0, 3'd0, 3'b100, 0, 1, 0, 0, 0, 0, 0);
    push(2, "shr1", 6'b100000, 0, 6'b100000, 0, 0, 16'h0);
    @(negedge clk);
    push(2, "shr2", 6'b110000, 0, 6'b110000, 0, 0, 16'h0);
    @(negedge clk); drive(3'd0, 3'd0, 3'b100, 0, 0, 1, 0, 0, 0, 0);
    push(2, "shl0", 6'b100000, 0, 6'b100000, 0, 0, 16'h0);

    // Shift after an invalid cycle starts from zero.
    @(negedge clk); opcode = 3'b111;
    push(2, "inv7", 6'd0, 1, 6'd0, 1, 1, 16'h0);
    @(negedge clk); drive(3'd0, 3'd0, 3'b100, 0, 1, 1, 0, 0, 0, 0);
    push(2, "shl_from0", 6'd1, 0, 6'd1, 0, 1, 16'h0);

    // Blink: invalid shows at offset 2; LEDs toggle at offsets 6, 10, 14.
    for (int i = 0; i < 13; i++) begin
      @(negedge clk); drive(3'd0, 3'd0, 3'b111, 0, 0, 0, 0, 0, 0, 0);
      exp_leds = (((i + 2) >= 6 && (i + 2) < 10) || (i + 2) >= 14) ? 16'hFFFF : 16'h0000;
      push(2, $sformatf("blink%0d", i), 6'd0, 1, 6'd0, 1, 1, exp_leds);
    end
    @(negedge clk); opcode = 3'b000;
    push(2, "blink_off", 6'd0, 0, 6'd0, 0, 1, 16'h0);

    guard = 0;
    while (sb_q.size() > 0 && guard < 20) begin
      @(negedge clk);
      #1 guard++;
    end
    checks++;
    assert (sb_q.size() == 0) else begin
      errors++;
      $error("FAIL sb_drain: observed=%0d pending expected=0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
